// File: rtl/cmd_phys_gen.sv
// rtl/cmd_phys_gen.sv - SD CMD-line PHY: command serialiser, response deserialiser, CRC7
// Define CMD_CRC7_EN to generate CRC7 on transmit and check it on receive.
module cmd_phys_gen #(
  parameter int CMD_W     = 40,
  parameter int SHORT_LEN = 48,
  parameter int LONG_LEN  = 136,
  parameter int TMO_W     = 16
) (
  input  logic                sd_clock,
  input  logic                reset,
  input  logic                strobe_in,
  input  logic                ack_in,
  input  logic                idle_in,
  input  logic [CMD_W-1:0]    cmd_to_send,
  input  logic [1:0]          resp_type,
  input  logic                timeout_enable,
  input  logic [TMO_W-1:0]    timeout_cycles,
  output logic                ack_out,
  output logic                strobe_out,
  output logic [LONG_LEN-1:0] response,
  output logic                cmd_timeout,
  output logic                crc_error,
  output logic                busy,
  output logic                cmd_out,
  output logic                cmd_oe,
  input  logic                cmd_in
);
  localparam int FRAME_W = CMD_W + 8;
  localparam int CNT_W   = $clog2(FRAME_W + LONG_LEN + 1);
  localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_LEN - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_TURN, S_WAIT, S_RECV, S_TOUT, S_DONE} state_t;
  state_t state;

  logic [FRAME_W-1:0]  tx_frame;
  logic [FRAME_W-1:0]  tx_shift;
  logic [6:0]          tx_crc;
  logic [LONG_LEN-2:0] rx_shift;
  logic [LONG_LEN-1:0] rx_next;
  logic                rx_bad;
  logic [CNT_W-1:0]    cnt;
  logic [TMO_W-1:0]    wait_cnt;
  logic [TMO_W-1:0]    tmo_limit;
  logic [1:0]          rtype;

  // CRC7 (x^7+x^3+1) over data[hi:lo], MSB first
  function automatic logic [6:0] crc7(input logic [LONG_LEN-1:0] data, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = LONG_LEN - 1; i >= 0; i--) begin
      if (i <= hi && i >= lo) begin
        fb = data[i] ^ c[6];
        c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
    end
    return c;
  endfunction

`ifdef CMD_CRC7_EN
  assign tx_crc = crc7(LONG_LEN'(cmd_to_send), CMD_W - 1, 0);
`else
  assign tx_crc = 7'h00;
`endif

  assign tx_frame = {cmd_to_send, tx_crc, 1'b1};
  assign rx_next  = {rx_shift, cmd_in};
  assign busy     = (state != S_IDLE);

  always_comb begin
    rx_bad = ~rx_next[0];
`ifdef CMD_CRC7_EN
    if (rtype == 2'b01)
      rx_bad = rx_bad | (crc7(rx_next, SHORT_LEN - 1, 8) != rx_next[7:1]);
    else if (rtype == 2'b10)
      rx_bad = rx_bad | (crc7(rx_next, LONG_LEN - 9, 8) != rx_next[7:1]);
`endif
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ack_out     <= 1'b0;
      strobe_out  <= 1'b0;
      response    <= '0;
      cmd_timeout <= 1'b0;
      crc_error   <= 1'b0;
      cmd_out     <= 1'b1;
      cmd_oe      <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      cnt         <= '0;
      wait_cnt    <= '0;
      tmo_limit   <= '0;
      rtype       <= 2'b00;
    end else begin
      ack_out <= 1'b0;
      if (idle_in) begin
        state       <= S_IDLE;
        cmd_oe      <= 1'b0;
        cmd_out     <= 1'b1;
        strobe_out  <= 1'b0;
        cmd_timeout <= 1'b0;
        crc_error   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (strobe_in) begin
            // first frame bit goes on the line together with ack_out
            rtype       <= resp_type;
            tmo_limit   <= timeout_cycles;
            tx_shift    <= tx_frame << 1;
            cmd_out     <= tx_frame[FRAME_W-1];
            cmd_oe      <= 1'b1;
            cnt         <= CNT_W'(1);
            ack_out     <= 1'b1;
            cmd_timeout <= 1'b0;
            crc_error   <= 1'b0;
            state       <= S_SEND;
          end
          S_SEND: if (cnt != FRAME_END) begin
            cmd_out  <= tx_shift[FRAME_W-1];
            tx_shift <= tx_shift << 1;
            cnt      <= cnt + 1'b1;
          end else begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            cnt     <= '0;
            if (rtype == 2'b00) begin
              response   <= '0;
              strobe_out <= 1'b1;
              state      <= S_DONE;
            end else begin
              state <= S_TURN;
            end
          end
          S_TURN: if (cnt != '0) begin
            cnt      <= '0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
          S_WAIT: if (!cmd_in) begin
            rx_shift <= '0;
            cnt      <= CNT_W'(1);
            state    <= S_RECV;
          end else if (timeout_enable && wait_cnt == tmo_limit) begin
            cmd_timeout <= 1'b1;
            state       <= S_TOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          S_RECV: begin
            rx_shift <= rx_next[LONG_LEN-2:0];
            cnt      <= cnt + 1'b1;
            if (cnt == ((rtype == 2'b10) ? LONG_LAST : SHORT_LAST)) begin
              response   <= rx_next;
              crc_error  <= rx_bad;
              strobe_out <= 1'b1;
              state      <= S_DONE;
            end
          end
          S_TOUT: begin
            response   <= '0;
            strobe_out <= 1'b1;
            state      <= S_DONE;
          end
          S_DONE: if (ack_in) begin
            strobe_out <= 1'b0;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cmd_phys_gen.sv
// tb/tb_cmd_phys_gen.sv - testbench for cmd_phys_gen (vector table, random commands, card model)
module tb_cmd_phys_gen;
`ifdef CMD_CRC7_EN
  localparam bit CRC_ON = 1'b1;
  localparam logic [47:0] CMD0_FRAME = 48'h40_0000_0000_95;
`else
  localparam bit CRC_ON = 1'b0;
  localparam logic [47:0] CMD0_FRAME = 48'h40_0000_0000_01;
`endif

  logic         sd_clock = 1'b0;
  logic         reset = 1'b0;
  logic         strobe_in = 1'b0;
  logic         ack_in = 1'b0;
  logic         idle_in = 1'b0;
  logic [39:0]  cmd_to_send = '0;
  logic [1:0]   resp_type = 2'b00;
  logic         timeout_enable = 1'b0;
  logic [15:0]  timeout_cycles = '0;
  logic         ack_out, strobe_out, cmd_timeout, crc_error, busy, cmd_out, cmd_oe;
  logic [135:0] response;
  logic         cmd_in = 1'b1;

  int total = 0;
  int bad = 0;

  cmd_phys_gen dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
    .idle_in(idle_in), .cmd_to_send(cmd_to_send), .resp_type(resp_type),
    .timeout_enable(timeout_enable), .timeout_cycles(timeout_cycles),
    .ack_out(ack_out), .strobe_out(strobe_out), .response(response),
    .cmd_timeout(cmd_timeout), .crc_error(crc_error), .busy(busy),
    .cmd_out(cmd_out), .cmd_oe(cmd_oe), .cmd_in(cmd_in)
  );

  always #5 sd_clock = ~sd_clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkb(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s: got %b expected %b", nm, got, exp); end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin bad++; $display("FAIL %s: got %0d expected %0d", nm, got, exp); end
  endtask

  task automatic chkv(input string nm, input logic [135:0] got, input logic [135:0] exp);
    total++;
    if (got !== exp) begin bad++; $display("FAIL %s: got %h expected %h", nm, got, exp); end
  endtask

  // CRC7 as the remainder of polynomial long division of M(x)*x^7 by x^7+x^3+1
  function automatic logic [6:0] ref_crc(input logic [135:0] v, input int hi, input int lo);
    bit r[$];
    logic [6:0] c;
    int n;
    for (int i = hi; i >= lo; i--) r.push_back(v[i]);
    repeat (7) r.push_back(1'b0);
    n = r.size();
    for (int i = 0; i < n - 7; i++)
      if (r[i]) begin r[i] ^= 1'b1; r[i+4] ^= 1'b1; r[i+7] ^= 1'b1; end
    for (int j = 0; j < 7; j++) c[6-j] = r[n-7+j];
    return c;
  endfunction

  function automatic logic [47:0] model_frame(input logic [39:0] c);
    logic [6:0] crc;
    crc = CRC_ON ? ref_crc({96'b0, c}, 39, 0) : 7'h00;
    return {c, crc, 1'b1};
  endfunction

  // card reply: kind 0 valid, 1 corrupted CRC field, 2 end bit 0
  function automatic logic [135:0] make_reply(input logic [1:0] rt, input int kind, input logic [135:0] rnd);
    int len;
    int hi;
    logic [135:0] r;
    len = (rt == 2'b10) ? 136 : 48;
    hi  = (rt == 2'b10) ? 127 : 47;
    r = rnd;
    for (int i = len; i < 136; i++) r[i] = 1'b0;
    r[len-1] = 1'b0;
    r[len-2] = 1'b0;
    r[7:1] = ref_crc(r, hi, 8);
    r[0] = 1'b1;
    if (kind == 1) r[1] = ~r[1];
    if (kind == 2) r[0] = 1'b0;
    return r;
  endfunction

  task automatic do_cmd(input string nm, input logic [39:0] cmd, input logic [1:0] rt, input logic ten,
                        input logic [15:0] tcy, input int dly, input logic [135:0] reply, input int hold,
                        input logic [47:0] x_frame, input logic [135:0] x_resp, input logic x_tmo,
                        input logic x_crc, input int x_lat);
    logic [47:0]  frame;
    logic [135:0] held;
    logic         drive, ok;
    int n, acks, idx, got, len, j;
    len = (rt == 2'b10) ? 136 : 48;
    drive = (rt != 2'b00) && !x_tmo;
    cmd_to_send = cmd; resp_type = rt; timeout_enable = ten; timeout_cycles = tcy;
    strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    chkb({nm, " ack_out"}, ack_out, 1'b1);
    chkb({nm, " tmo cleared"}, cmd_timeout, 1'b0);
    chkb({nm, " crc cleared"}, crc_error, 1'b0);
    frame = '0; n = 0; acks = 0;
    while (cmd_oe && n < 100) begin
      frame = {frame[46:0], cmd_out};
      n++;
      if (ack_out) acks++;
      strobe_in = (n >= 10 && n < 14);
      @(negedge sd_clock);
    end
    strobe_in = 1'b0;
    chki({nm, " oe cycles"}, n, 48);
    chkv({nm, " frame"}, {88'b0, frame}, {88'b0, x_frame});
    chki({nm, " ack pulses"}, acks, 1);
    idx = 0; got = -1;
    while (idx < 400) begin
      if (strobe_out) begin got = idx; break; end
      cmd_in = 1'b1;
      j = idx - 2 - dly;
      if (drive && j >= 0 && j < len) cmd_in = reply[len-1-j];
      @(negedge sd_clock);
      idx++;
    end
    cmd_in = 1'b1;
    chki({nm, " latency"}, got, x_lat);
    chkv({nm, " response"}, response, x_resp);
    chkb({nm, " cmd_timeout"}, cmd_timeout, x_tmo);
    chkb({nm, " crc_error"}, crc_error, x_crc);
    chkb({nm, " busy done"}, busy, 1'b1);
    held = response; ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge sd_clock);
      if (strobe_out !== 1'b1 || response !== held) ok = 1'b0;
    end
    chkb({nm, " held until ack"}, ok, 1'b1);
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    chkb({nm, " strobe after ack"}, strobe_out, 1'b0);
    chkb({nm, " busy after ack"}, busy, 1'b0);
    chkb({nm, " tmo kept"}, cmd_timeout, x_tmo);
    chkb({nm, " crc kept"}, crc_error, x_crc);
  endtask

  typedef struct {
    logic [39:0] cmd;
    logic [1:0]  rt;
    logic        ten;
    logic [15:0] tcy;
    int          dly;
    int          kind;
    int          hold;
    logic        use_frame;
    logic [47:0] frame;
    logic        x_tmo;
    logic        x_crc;
    int          x_lat;
  } vec_t;

  vec_t vt[10];
  logic [159:0] rnd;
  logic [135:0] reply, x_resp;
  logic [39:0]  cmd;
  logic [1:0]   rt;
  logic         ten, drive, x_tmo, x_crc;
  logic [15:0]  tcy;
  int dly, kind, hold, len, hi, x_lat;

  initial begin
    vt[0] = '{40'h40_0000_0000, 2'd0, 1'b0, 16'd0,  0,  0,  0, 1'b1, CMD0_FRAME, 1'b0, 1'b0,   0};
    vt[1] = '{40'h51_0000_0000, 2'd1, 1'b0, 16'd0,  5,  0,  0, 1'b0, 48'h0,      1'b0, 1'b0,  55};
    vt[2] = '{40'h42_0000_0000, 2'd2, 1'b0, 16'd0,  3,  1,  1, 1'b0, 48'h0,      1'b0, CRC_ON, 141};
    vt[3] = '{40'h4D_1234_0000, 2'd1, 1'b1, 16'd10, -1, 0,  2, 1'b0, 48'h0,      1'b1, 1'b0,  14};
    vt[4] = '{40'h4D_0000_0001, 2'd1, 1'b1, 16'd0,  -1, 0,  0, 1'b0, 48'h0,      1'b1, 1'b0,   4};
    vt[5] = '{40'h48_0000_01AA, 2'd1, 1'b1, 16'd4,  4,  0,  0, 1'b0, 48'h0,      1'b0, 1'b0,  54};
    vt[6] = '{40'h69_4000_0000, 2'd3, 1'b0, 16'd0,  0,  1,  0, 1'b0, 48'h0,      1'b0, 1'b0,  50};
    vt[7] = '{40'h51_0000_0200, 2'd1, 1'b0, 16'd0,  2,  2,  0, 1'b0, 48'h0,      1'b0, 1'b1,  52};
    vt[8] = '{40'h49_0001_0000, 2'd2, 1'b0, 16'd0,  0,  0, 50, 1'b0, 48'h0,      1'b0, 1'b0, 138};
    vt[9] = '{40'h57_0000_0200, 2'd1, 1'b0, 16'd0,  20, 0,  0, 1'b0, 48'h0,      1'b0, 1'b0,  70};

    repeat (3) @(negedge sd_clock);
    chkb("reset cmd_out", cmd_out, 1'b1);
    chkb("reset cmd_oe", cmd_oe, 1'b0);
    chkb("reset ack_out", ack_out, 1'b0);
    chkb("reset strobe_out", strobe_out, 1'b0);
    chkb("reset busy", busy, 1'b0);
    chkb("reset flags", cmd_timeout | crc_error, 1'b0);
    chkv("reset response", response, '0);
    reset = 1'b1;
    @(negedge sd_clock);

    for (int i = 0; i < 10; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      reply = make_reply(vt[i].rt, vt[i].kind, rnd[135:0]);
      drive = (vt[i].rt != 2'b00) && !vt[i].x_tmo;
      do_cmd($sformatf("vec%0d", i), vt[i].cmd, vt[i].rt, vt[i].ten, vt[i].tcy, vt[i].dly, reply,
             vt[i].hold, vt[i].use_frame ? vt[i].frame : model_frame(vt[i].cmd),
             drive ? reply : '0, vt[i].x_tmo, vt[i].x_crc, vt[i].x_lat);
    end

    for (int k = 0; k < 40; k++) begin
      cmd  = {2'b01, 6'($urandom_range(63, 0)), $urandom()};
      rt   = 2'($urandom_range(3, 0));
      ten  = 1'($urandom_range(1, 0));
      tcy  = 16'($urandom_range(15, 0));
      dly  = int'($urandom_range(21, 0)) - 1;
      if (!ten && dly < 0) dly = 7;
      kind = int'($urandom_range(2, 0));
      hold = int'($urandom_range(3, 0));
      len  = (rt == 2'b10) ? 136 : 48;
      hi   = (rt == 2'b10) ? 127 : 47;
      rnd  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      reply = make_reply(rt, kind, rnd[135:0]);
      x_tmo = (rt != 2'b00) && ten && (dly < 0 || dly > int'(tcy));
      drive = (rt != 2'b00) && !x_tmo;
      x_resp = drive ? reply : '0;
      x_crc = drive && (!reply[0] || (CRC_ON && rt != 2'b11 && reply[7:1] != ref_crc(reply, hi, 8)));
      x_lat = (rt == 2'b00) ? 0 : (x_tmo ? 4 + int'(tcy) : dly + len + 2);
      do_cmd($sformatf("rnd%0d", k), cmd, rt, ten, tcy, dly, reply, hold, model_frame(cmd),
             x_resp, x_tmo, x_crc, x_lat);
    end

    // abort during SEND after a response with a bad end bit: flags clear, response kept
    rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    reply = make_reply(2'b01, 2, rnd[135:0]);
    do_cmd("pre_abort", 40'h51_0000_0000, 2'b01, 1'b0, 16'd0, 1, reply, 0,
           model_frame(40'h51_0000_0000), reply, 1'b0, 1'b1, 51);
    cmd_to_send = 40'h52_AAAA_5555; resp_type = 2'b01; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (20) @(negedge sd_clock);
    chkb("abort oe before", cmd_oe, 1'b1);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    chkb("abort cmd_oe", cmd_oe, 1'b0);
    chkb("abort cmd_out", cmd_out, 1'b1);
    chkb("abort busy", busy, 1'b0);
    chkb("abort strobe_out", strobe_out, 1'b0);
    chkb("abort crc_error", crc_error, 1'b0);
    chkv("abort response kept", response, reply);
    do_cmd("post_abort", 40'h40_0000_0000, 2'b00, 1'b0, 16'd0, 0, '0, 0, CMD0_FRAME, '0, 1'b0, 1'b0, 0);

    // asynchronous reset mid-frame releases the line without a clock edge
    cmd_to_send = 40'h51_0000_0000; resp_type = 2'b01; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    repeat (10) @(negedge sd_clock);
    reset = 1'b0;
    #1;
    chkb("async rst cmd_oe", cmd_oe, 1'b0);
    chkb("async rst cmd_out", cmd_out, 1'b1);
    chkb("async rst busy", busy, 1'b0);
    chkv("async rst response", response, '0);
    @(negedge sd_clock);
    reset = 1'b1;
    @(negedge sd_clock);
    do_cmd("post_reset", 40'h40_0000_0000, 2'b00, 1'b0, 16'd0, 0, '0, 0, CMD0_FRAME, '0, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
